e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 139 +++++++++++++
 tb/tb_e_mdu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with a busy window, HI/LO registers,
// and single-cycle mthi/mtlo writes.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;

   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg, is_div;
   logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
   logic [31:0] res_hi, res_lo;

   // Result datapath from latched operands; signed divide works on magnitudes so
   // 0x80000000 / -1 wraps cleanly instead of overflowing.
   always_comb begin
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'b0, a_q} * {32'b0, b_q};
      is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
      a_neg  = (op_q == OP_DIV) && a_q[31];
      b_neg  = (op_q == OP_DIV) && b_q[31];
      a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
      b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
      b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_div;
      r_mag  = a_mag % b_div;
      quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
      res_hi = hi_q;
      res_lo = lo_q;
      case (op_q)
         OP_MULT:           begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
         OP_MULTU:          begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
         OP_DIV, OP_DIVU:   begin res_hi = rem;           res_lo = quo;          end
         default:           ;
      endcase
   end

   // Next-state and register-update logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (mdu_op)
                  OP_MULT, OP_MULTU: begin
                     state_d = RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = mdu_op;
                     a_d     = A;
                     b_d     = B;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = mdu_op;
                     a_d     = A;
                     b_d     = B;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               // Divide by zero leaves HI/LO untouched.
               if (!(is_div && (b_q == 32'd0))) begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Randomised and directed bench for e_mdu against a cycle-level arithmetic model.
module tb_e_mdu;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_hi, m_lo, m_a, m_b;
   logic [2:0]  m_op;
   int          m_rem;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {HI, LO} computed with wide integer arithmetic.
   function automatic logic [63:0] result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int                sa_i, sb_i;
      longint            sa, sb, sq, sr;
      longint unsigned   ua, ub, up;
      sa_i = a;
      sb_i = b;
      sa = sa_i;
      sb = sb_i;
      ua = a;
      ub = b;
      case (op)
         3'd1: begin sq = sa * sb; return sq; end
         3'd2: begin up = ua * ub; return up; end
         3'd3: begin sq = sa / sb; sr = sa % sb; return {sr[31:0], sq[31:0]}; end
         3'd4: return {b == 0 ? 32'd0 : a % b, b == 0 ? 32'd0 : a / b};
         default: return 64'd0;
      endcase
   endfunction

   task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = st;
      mdu_op = op;
      A      = a;
      B      = b;
   endtask

   // One clock: advance the model on the edge, then compare outputs.
   task automatic step();
      @(posedge clk);
      if (reset) begin
         m_hi = 0; m_lo = 0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && !((m_op == 3'd3 || m_op == 3'd4) && m_b == 0))
            {m_hi, m_lo} = result(m_op, m_a, m_b);
      end else if (start) begin
         case (mdu_op)
            3'd1, 3'd2: begin m_op = mdu_op; m_a = A; m_b = B; m_rem = MC; end
            3'd3, 3'd4: begin m_op = mdu_op; m_a = A; m_b = B; m_rem = DC; end
            3'd5: m_hi = A;
            3'd6: m_lo = A;
            default: ;
         endcase
      end
      #1;
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("hi", 64'(HI), 64'(m_hi));
      check("lo", 64'(LO), 64'(m_lo));
   endtask

   // Issue an op for one cycle, scramble operands, and count busy cycles (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
      drive(1'b1, op, a, b);
      step();
      drive(1'b0, 3'd0, $urandom, $urandom);
      cyc = 0;
      while (busy && cyc < 64) begin
         cyc++;
         step();
      end
   endtask

   logic [31:0] pick [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h2};

   initial begin
      int cyc;
      logic [31:0] save_lo;
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0; m_rem = 0;
      reset = 1'b1;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      step();
      step();
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hi", 64'(HI), 64'd0);
      reset = 1'b0;

      run_op(3'd1, 32'hFFFF_FFFD, 32'd5, cyc);
      check("mult_len", 64'(cyc), 64'(MC));
      check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
      check("mult_lo", 64'(LO), 64'hFFFF_FFF1);

      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, cyc);
      check("multu_len", 64'(cyc), 64'(MC));
      check("multu_hi", 64'(HI), 64'h1);
      check("multu_lo", 64'(LO), 64'hFFFF_FFFE);

      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
      check("div_len", 64'(cyc), 64'(DC));
      check("div_lo", 64'(LO), 64'hFFFF_FFFD);
      check("div_hi", 64'(HI), 64'hFFFF_FFFF);

      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      check("divovf_lo", 64'(LO), 64'h8000_0000);
      check("divovf_hi", 64'(HI), 64'h0);

      drive(1'b1, 3'd5, 32'h1234_5678, 32'd0);
      step();
      check("mthi_hi", 64'(HI), 64'h1234_5678);
      check("mthi_busy", 64'(busy), 64'd0);
      save_lo = LO;
      run_op(3'd4, 32'd7, 32'd0, cyc);
      check("div0_len", 64'(cyc), 64'(DC));
      check("div0_hi", 64'(HI), 64'h1234_5678);
      check("div0_lo", 64'(LO), 64'(save_lo));

      // mtlo presented while busy is ignored, then taken in the cycle busy falls
      drive(1'b1, 3'd1, 32'd3, 32'd4);
      step();
      drive(1'b1, 3'd6, 32'hAAAA_AAAA, 32'd0);
      cyc = 0;
      while (busy && cyc < 64) begin
         cyc++;
         step();
      end
      check("stall_len", 64'(cyc), 64'(MC));
      check("stall_lo_mult", 64'(LO), 64'd12);
      step();
      check("mtlo_lo", 64'(LO), 64'hAAAA_AAAA);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      step();

      // reset in the middle of a divide aborts it
      drive(1'b1, 3'd3, 32'd100, 32'd7);
      step();
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(HI), 64'd0);
      check("abort_lo", 64'(LO), 64'd0);
      repeat (DC + 2) step();
      check("abort_late_lo", 64'(LO), 64'd0);

      // random traffic, including back-to-back and specials
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb);
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
